ifu_fetch: RTL and testbench

Instruction fetch unit for the pipelined MIPS core: owns the program counter, drives the word address into the instruction memory, and registers the returned instruction into the IF/ID pipeline register. It applies stall, branch, jump and register-jump redirects issued from decode, and preserves MIPS branch-delay-slot semantics. The instruction memory is a combinational read port (10-bit word address in, 32-bit instruction out); this block is its sole reader.

---
 rtl/ifu_fetch.sv | 97 +++++++++
 tb/tb_ifu_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: program counter, IM address generation and IF/ID register.
// Applies stall and jr/j/branch redirects from decode with MIPS delay-slot semantics.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_instr,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              j_en,
  input  logic [25:0]       j_index,
  input  logic              jr_en,
  input  logic [31:0]       jr_target,
  output logic [31:0]       pc,
  output logic [31:0]       id_instr,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc8,
  output logic              id_valid,
  output logic              addr_err
);

  localparam int unsigned OFF_W = 30;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      id_instr_q, id_instr_d;
  logic [31:0]      id_pc_q, id_pc_d;
  logic             id_valid_q, id_valid_d;
  logic             addr_err_q, addr_err_d;
  logic [OFF_W-1:0] off_w;
  logic             fetch_fault;
  logic [31:0]      id_pc4;
  logic [31:0]      br_target;
  logic [31:0]      j_target;

  // Word offset of the fetch PC from the IM base; wraps so PCs below the base fault too.
  assign off_w       = pc_q[31:2] - PC_RESET[31:2];
  assign im_addr     = off_w[ADDR_W-1:0];
  assign fetch_fault = (pc_q[1:0] != 2'b00) || (off_w[OFF_W-1:ADDR_W] != '0);

  // Redirect targets are relative to the instruction in ID.
  assign id_pc4    = id_pc_q + 32'd4;
  assign br_target = id_pc4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign j_target  = {id_pc4[31:28], j_index, 2'b00};

  // Next PC and IF/ID contents; everything holds while stalled.
  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    addr_err_d = addr_err_q;
    if (!stall) begin
      id_instr_d = fetch_fault ? 32'h0 : im_instr;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      addr_err_d = addr_err_q | fetch_fault;
      if (id_valid_q && jr_en) begin
        pc_d = jr_target;
      end else if (id_valid_q && j_en) begin
        pc_d = j_target;
      end else if (id_valid_q && br_taken) begin
        pc_d = br_target;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // PC and IF/ID pipeline register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_RESET;
      id_instr_q <= 32'h0;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;
  assign addr_err = addr_err_q;
  assign id_pc8   = id_pc_q + 32'd8;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: behavioural IM, expected IF/ID contents queued per step.
module tb_ifu_fetch;

  localparam int unsigned ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_instr;
  logic              stall;
  logic              br_taken;
  logic [15:0]       br_offset;
  logic              j_en;
  logic [25:0]       j_index;
  logic              jr_en;
  logic [31:0]       jr_target;
  logic [31:0]       pc;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc;
  logic [31:0]       id_pc8;
  logic              id_valid;
  logic              addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] idpc;
    logic [31:0] pc;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t sb[$];

  ifu_fetch #(.PC_RESET(32'h0000_3000), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_instr(im_instr),
    .stall(stall), .br_taken(br_taken), .br_offset(br_offset),
    .j_en(j_en), .j_index(j_index), .jr_en(jr_en), .jr_target(jr_target),
    .pc(pc), .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8),
    .id_valid(id_valid), .addr_err(addr_err)
  );

  // IM word k holds 0x1000_0000 + k.
  assign im_instr = 32'h1000_0000 + 32'(im_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'h3000;
    if (a[1:0] != 2'b00 || off >= 32'h1000) return 32'h0;
    return 32'h1000_0000 + (off >> 2);
  endfunction

  task automatic push(input logic [31:0] idpc, input logic [31:0] npc, input logic err);
    exp_t e;
    e.instr = word_at(idpc);
    e.idpc  = idpc;
    e.pc    = npc;
    e.valid = 1'b1;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"}, pc, 32'h3000);
    chk({tag, "_instr"}, id_instr, 32'h0);
    chk({tag, "_idpc"}, id_pc, 32'h0);
    chk({tag, "_valid"}, 32'(id_valid), 32'h0);
    chk({tag, "_err"}, 32'(addr_err), 32'h0);
    chk({tag, "_imaddr"}, 32'(im_addr), 32'h0);
    chk({tag, "_pc8"}, id_pc8, 32'h8);
  endtask

  // Advance one clock and compare against the oldest queued expectation.
  task automatic step(input string tag);
    exp_t e;
    logic [31:0] eaddr;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    eaddr = (e.pc - 32'h3000) >> 2;
    chk({tag, "_instr"}, id_instr, e.instr);
    chk({tag, "_idpc"}, id_pc, e.idpc);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_valid"}, 32'(id_valid), 32'(e.valid));
    chk({tag, "_err"}, 32'(addr_err), 32'(e.err));
    chk({tag, "_pc8"}, id_pc8, e.idpc + 32'd8);
    chk({tag, "_imaddr"}, 32'(im_addr), 32'(eaddr[ADDR_W-1:0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_offset = '0;
    j_en = 1'b0; j_index = '0; jr_en = 1'b0; jr_target = '0;
    #12;
    check_reset("rst");
    rst_n = 1'b1;

    // Free-running sequential fetch.
    push(32'h3000, 32'h3004, 1'b0); step("seq0");
    push(32'h3004, 32'h3008, 1'b0); step("seq1");
    push(32'h3008, 32'h300C, 1'b0); step("seq2");
    push(32'h300C, 32'h3010, 1'b0); step("seq3");

    // Backward branch from 0x3004 with offset -2 words.
    do_reset();
    push(32'h3000, 32'h3004, 1'b0); step("br_pre0");
    push(32'h3004, 32'h3008, 1'b0); step("br_pre1");
    br_taken = 1'b1; br_offset = 16'hFFFE;
    push(32'h3008, 32'h3000, 1'b0); step("br_slot");
    br_taken = 1'b0;
    push(32'h3000, 32'h3004, 1'b0); step("br_tgt");

    // jr has priority over j and branch.
    jr_en = 1'b1; jr_target = 32'h3040; j_en = 1'b1; j_index = 26'h0C0_0010;
    br_taken = 1'b1; br_offset = 16'h0010;
    push(32'h3004, 32'h3040, 1'b0); step("pri_slot");
    jr_en = 1'b0; j_en = 1'b0; br_taken = 1'b0;
    push(32'h3040, 32'h3044, 1'b0); step("pri_tgt");

    // Plain jump to 0x3020.
    j_en = 1'b1; j_index = 26'h000_0C08;
    push(32'h3044, 32'h3020, 1'b0); step("j_slot");
    j_en = 1'b0;
    push(32'h3020, 32'h3024, 1'b0); step("j_tgt");

    // Stall for three cycles with a branch pending.
    stall = 1'b1; br_taken = 1'b1; br_offset = 16'h0004;
    push(32'h3020, 32'h3024, 1'b0); step("stall0");
    push(32'h3020, 32'h3024, 1'b0); step("stall1");
    push(32'h3020, 32'h3024, 1'b0); step("stall2");
    stall = 1'b0;
    push(32'h3024, 32'h3034, 1'b0); step("unstall_slot");
    br_taken = 1'b0;
    push(32'h3034, 32'h3038, 1'b0); step("unstall_tgt");

    // Faulting fetch addresses: misaligned, below base, beyond IM.
    jr_en = 1'b1; jr_target = 32'h3002;
    push(32'h3038, 32'h3002, 1'b0); step("flt_slot");
    jr_target = 32'h2FFC;
    push(32'h3002, 32'h2FFC, 1'b1); step("flt_mis");
    jr_target = 32'h7000;
    push(32'h2FFC, 32'h7000, 1'b1); step("flt_low");
    jr_en = 1'b0;
    push(32'h7000, 32'h7004, 1'b1); step("flt_high");

    // Asynchronous reset in the middle of a taken-branch cycle.
    do_reset();
    push(32'h3000, 32'h3004, 1'b0); step("ar_pre0");
    push(32'h3004, 32'h3008, 1'b0); step("ar_pre1");
    br_taken = 1'b1; br_offset = 16'hFFFE;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    @(posedge clk);
    #1;
    check_reset("async_hold");
    br_taken = 1'b0;
    rst_n = 1'b1;
    push(32'h3000, 32'h3004, 1'b0); step("ar_post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
